// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Instruction buffer between the fetch unit / I-cache and decode.
//   Each cycle it accepts a fetch group of up to two instructions with a
//   per-slot valid mask. Valid slots are compacted into a circular FIFO of
//   {pc, inst} entries. Entries go to decode as aligned pairs, with out[0]
//   always the older instruction. Decode back-pressure is absorbed here. A
//   pipeline flush empties the buffer on the next edge.
//
// Ports
//   clk         in   clock
//   rst         in   asynchronous reset, active-high
//   flush       in   synchronous pipeline flush (mispredict / exception)
//   ic_val      in   fetch group valid
//   ic_mask     in   per-slot valid, bit0 = older slot
//   ic_pcs      in   slot PCs, [0] = older slot
//   ic_insts    in   slot instructions, [0] = older slot
//   ibuf_rdy    out  buffer has room for a full group (two entries)
//   decode_rdy  in   decode accepts the presented pair this cycle
//   fetch_val   out  inst_pcs / insts carry valid instructions
//   inst_pcs    out  PCs to decode, [0] = older
//   insts       out  instructions to decode, [0] = older
// -----------------------------------------------------------------------------
module inst_buffer #(
  parameter int DEPTH         = 8,
  parameter int PIPE_WIDTH    = 2,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic                                     ic_val,
  input  logic [PIPE_WIDTH-1:0]                    ic_mask,
  input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] ic_pcs,
  input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] ic_insts,
  output logic                                     ibuf_rdy,
  input  logic                                     decode_rdy,
  output logic                                     fetch_val,
  output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs,
  output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Storage. The array is not reset: an entry is only read once count says
  // it was written.
  // ---------------------------------------------------------------------------
  logic [CPU_ADDR_BITS-1:0] pc_mem   [DEPTH];
  logic [CPU_INST_BITS-1:0] inst_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Pointer / occupancy state
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [PTR_W-1:0] tail_p1;
  logic             pad_mode;
  logic             enq_fire;
  logic             deq_fire;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;

  assign tail_p1 = tail_reg + PTR_W'(1);

  // Room for a full group, judged from registered occupancy only. A dequeue
  // in the same cycle does not open the buffer early. This keeps ibuf_rdy
  // off the decode_rdy timing path.
  assign ibuf_rdy = (count_reg <= CNT_W'(DEPTH - 2));

  // A lone entry is padded out to a pair only when no new group is
  // arriving. If a group is arriving, it is better to wait one cycle so the
  // entry can go out as a real pair.
  assign pad_mode  = (count_reg == CNT_W'(1)) && !ic_val;
  assign fetch_val = !flush && ((count_reg >= CNT_W'(2)) || pad_mode);

  assign enq_fire = ic_val && ibuf_rdy && !flush;
  assign deq_fire = fetch_val && decode_rdy;

  assign n_enq = enq_fire ? ({1'b0, ic_mask[0]} + {1'b0, ic_mask[1]}) : 2'd0;
  assign n_deq = deq_fire ? (pad_mode ? 2'd1 : 2'd2) : 2'd0;

  // ---------------------------------------------------------------------------
  // Enqueue compaction. Write port 0 always lands at tail. It takes slot0
  // when slot0 is valid, otherwise slot1 (mask 10 compacts slot1 down).
  // Write port 1 lands at tail+1 and is used only when both slots are valid.
  // ---------------------------------------------------------------------------
  logic                     wr0_en;
  logic                     wr1_en;
  logic [CPU_ADDR_BITS-1:0] wr0_pc;
  logic [CPU_INST_BITS-1:0] wr0_inst;

  assign wr0_en   = enq_fire && (ic_mask != 2'b00);
  assign wr1_en   = enq_fire && (ic_mask == 2'b11);
  assign wr0_pc   = ic_mask[0] ? ic_pcs[0]   : ic_pcs[1];
  assign wr0_inst = ic_mask[0] ? ic_insts[0] : ic_insts[1];

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_mem[tail_reg]   <= wr0_pc;
      inst_mem[tail_reg] <= wr0_inst;
    end
    if (wr1_en) begin
      pc_mem[tail_p1]   <= ic_pcs[1];
      inst_mem[tail_p1] <= ic_insts[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: slot gi of the presented pair reads entry head+gi. Pointers
  // wrap naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] rd_pc;
  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] rd_inst;

  for (genvar gi = 0; gi < PIPE_WIDTH; gi++) begin : g_rd
    logic [PTR_W-1:0] rd_ptr;
    assign rd_ptr      = head_reg + PTR_W'(gi);
    assign rd_pc[gi]   = pc_mem[rd_ptr];
    assign rd_inst[gi] = inst_mem[rd_ptr];
  end

  // In pad mode the younger slot is a synthetic all-zero instruction at the
  // next sequential PC. Decode treats opcode 0 as invalid and turns it into
  // a bubble.
  always_comb begin
    inst_pcs = rd_pc;
    insts    = rd_inst;
    if (pad_mode) begin
      inst_pcs[1] = rd_pc[0] + CPU_ADDR_BITS'(4);
      insts[1]    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state. Flush wins over any enqueue or dequeue in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + PTR_W'(n_deq);
      tail_next  = tail_reg + PTR_W'(n_enq);
      count_next = count_reg + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

`ifndef SYNTHESIS
  // Occupancy stays within [0, DEPTH]. An enqueue never overfills the
  // buffer, and a dequeue never pops more entries than are held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_reg <= CNT_W'(DEPTH));
      assert ((CNT_W+1)'(count_reg) + (CNT_W+1)'(n_enq) >= (CNT_W+1)'(n_deq));
      assert ((CNT_W+1)'(count_reg) + (CNT_W+1)'(n_enq) <= (CNT_W+1)'(DEPTH));
    end
  end
`endif

endmodule
